// File: rtl/prog_down_counter.sv
// Programmable WIDTH-bit counter with manual load/divide/step operations and
// a prescaled countdown timer mode with optional auto-reload.
// Status outputs (count, flags, running) are read-only views of internal state.
module prog_down_counter #(
    parameter int WIDTH     = 8,
    parameter int STEP_W    = 4,
    parameter int DIV_SHIFT = 1,
    parameter int PRESCALE  = 4,
    parameter int WRAP      = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             latch,
    input  logic [WIDTH-1:0] in,
    input  logic             div,
    input  logic             dec,
    input  logic             inc,
    input  logic [STEP_W-1:0] step,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             zero_pulse,
    output logic             underflow,
    output logic             overflow,
    output logic             running
);

    // Prescaler needs at least one bit even when PRESCALE == 1 (tick every cycle).
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int W1 = WIDTH + 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            underflow_q, underflow_d;
    logic            overflow_q, overflow_d;
    // Previous-cycle zero flag; resets to 1 so reset release never pulses.
    logic            zero_prev_q;

    logic [W1-1:0]   step_ext;
    logic [W1-1:0]   diff;
    logic [W1-1:0]   sum;
    logic            tick;

    // Arithmetic is done one bit wider so the top bit flags borrow/carry.
    always_comb begin
        step_ext = W1'(step);
        diff     = {1'b0, count_q} - step_ext;
        sum      = {1'b0, count_q} + step_ext;
        tick     = (state_q == RUN) && (presc_q == PRESC_LAST);
    end

    // Next-state logic: prescaler, manual ops (latch > div > dec > inc), timer tick, FSM.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        reload_d    = reload_q;
        presc_d     = presc_q;
        underflow_d = 1'b0;
        overflow_d  = 1'b0;

        // Prescaler free-runs in RUN even when a manual op steals the tick.
        if (state_q == RUN) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
        end

        if (latch) begin
            count_d  = in;
            reload_d = in;
        end else if (div) begin
            count_d = count_q >> DIV_SHIFT;
        end else if (dec) begin
            if (step != '0) begin
                if (diff[WIDTH]) begin
                    underflow_d = 1'b1;
                    count_d     = (WRAP != 0) ? diff[WIDTH-1:0] : '0;
                end else begin
                    count_d = diff[WIDTH-1:0];
                end
            end
        end else if (inc) begin
            if (step != '0) begin
                if (sum[WIDTH]) begin
                    overflow_d = 1'b1;
                    count_d    = (WRAP != 0) ? sum[WIDTH-1:0] : '1;
                end else begin
                    count_d = sum[WIDTH-1:0];
                end
            end
        end else if (tick && !stop) begin
            // Timer tick: count down, reload or fall back to IDLE at the bottom.
            if (count_q > WIDTH'(1)) begin
                count_d = count_q - WIDTH'(1);
            end else if (count_q == WIDTH'(1)) begin
                count_d = '0;
                if (!auto_reload) begin
                    state_d = IDLE;
                end
            end else begin
                if (auto_reload && (reload_q != '0)) begin
                    count_d = reload_q;
                end else begin
                    state_d = IDLE;
                end
            end
        end

        case (state_q)
            IDLE: begin
                // Nothing to count down from: refuse to start.
                if (start && !stop && !((count_q == '0) && (reload_q == '0))) begin
                    state_d = RUN;
                    presc_d = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            reload_q    <= '0;
            presc_q     <= '0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            reload_q    <= reload_d;
            presc_q     <= presc_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
            zero_prev_q <= zero;
        end
    end

    // Status outputs.
    always_comb begin
        count      = count_q;
        zero       = (count_q == '0);
        zero_pulse = zero & ~zero_prev_q & ~reset;
        underflow  = underflow_q;
        overflow   = overflow_q;
        running    = (state_q == RUN);
    end

endmodule

// File: tb/tb_prog_down_counter.sv
// Directed bench for prog_down_counter: a saturating and a wrapping instance
// share stimulus; expected status words are queued as each step is driven and
// popped when the outputs are sampled one time unit after the clock edge.
module tb_prog_down_counter;

    localparam int EW = 13;

    logic       clk;
    logic       reset;
    logic       latch;
    logic [7:0] in_v;
    logic       div;
    logic       dec;
    logic       inc;
    logic [3:0] step;
    logic       start;
    logic       stop;
    logic       auto_reload;

    logic [7:0] count_s, count_w;
    logic       zero_s, zero_w;
    logic       zp_s, zp_w;
    logic       uf_s, uf_w;
    logic       of_s, of_w;
    logic       run_s, run_w;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp_w_q[$];

    int n_cmp;
    int n_fail;

    prog_down_counter #(
        .WIDTH(8), .STEP_W(4), .DIV_SHIFT(1), .PRESCALE(4), .WRAP(0)
    ) u_sat (
        .clk(clk), .reset(reset), .latch(latch), .in(in_v), .div(div),
        .dec(dec), .inc(inc), .step(step), .start(start), .stop(stop),
        .auto_reload(auto_reload), .count(count_s), .zero(zero_s),
        .zero_pulse(zp_s), .underflow(uf_s), .overflow(of_s), .running(run_s)
    );

    prog_down_counter #(
        .WIDTH(8), .STEP_W(4), .DIV_SHIFT(1), .PRESCALE(4), .WRAP(1)
    ) u_wrap (
        .clk(clk), .reset(reset), .latch(latch), .in(in_v), .div(div),
        .dec(dec), .inc(inc), .step(step), .start(start), .stop(stop),
        .auto_reload(auto_reload), .count(count_w), .zero(zero_w),
        .zero_pulse(zp_w), .underflow(uf_w), .overflow(of_w), .running(run_w)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [EW-1:0] pk(input logic [7:0] c, input logic z,
                                         input logic zp, input logic uf,
                                         input logic of, input logic rn);
        return {c, z, zp, uf, of, rn};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [EW-1:0] e);
        exp_q.push_back(e);
    endtask

    task automatic push_w(input logic [EW-1:0] e);
        exp_w_q.push_back(e);
    endtask

    task automatic compare(input string tag, input logic [EW-1:0] o, input logic [EW-1:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed cnt=%0d z=%b zp=%b uf=%b of=%b run=%b, expected cnt=%0d z=%b zp=%b uf=%b of=%b run=%b",
                   tag, o[12:5], o[4], o[3], o[2], o[1], o[0],
                   e[12:5], e[4], e[3], e[2], e[1], e[0]);
        end
    endtask

    task automatic chk(input string tag);
        logic [EW-1:0] o;
        o = {count_s, zero_s, zp_s, uf_s, of_s, run_s};
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: no expected entry queued", tag);
        end else begin
            compare(tag, o, exp_q.pop_front());
        end
    endtask

    task automatic chk_w(input string tag);
        logic [EW-1:0] o;
        o = {count_w, zero_w, zp_w, uf_w, of_w, run_w};
        if (exp_w_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: no expected entry queued", tag);
        end else begin
            compare(tag, o, exp_w_q.pop_front());
        end
    endtask

    initial begin
        int c;
        int n;
        logic zp;

        n_cmp  = 0;
        n_fail = 0;
        reset = 1'b1; latch = 1'b0; in_v = '0; div = 1'b0; dec = 1'b0;
        inc = 1'b0; step = '0; start = 1'b0; stop = 1'b0; auto_reload = 1'b0;

        // Reset values while held and after release (no zero_pulse on release).
        cyc(); cyc();
        push(pk(8'd0, 1, 0, 0, 0, 0)); chk("reset_hold");
        push_w(pk(8'd0, 1, 0, 0, 0, 0)); chk_w("reset_hold_w");
        reset = 1'b0;
        push(pk(8'd0, 1, 0, 0, 0, 0)); cyc(); chk("reset_release");

        // Latch, divide, decrement.
        latch = 1'b1; in_v = 8'd16;
        push(pk(8'd16, 0, 0, 0, 0, 0)); cyc(); chk("t1_latch");
        latch = 1'b0; div = 1'b1;
        push(pk(8'd8, 0, 0, 0, 0, 0)); cyc(); chk("t1_div");
        div = 1'b0; dec = 1'b1; step = 4'd1;
        push(pk(8'd7, 0, 0, 0, 0, 0)); cyc(); chk("t1_dec1");
        push(pk(8'd6, 0, 0, 0, 0, 0)); cyc(); chk("t1_dec2");
        push(pk(8'd5, 0, 0, 0, 0, 0)); cyc(); chk("t1_dec3");
        dec = 1'b0;

        // Underflow: saturate to 0 vs wrap to 253.
        latch = 1'b1; in_v = 8'd2;
        push(pk(8'd2, 0, 0, 0, 0, 0)); push_w(pk(8'd2, 0, 0, 0, 0, 0));
        cyc(); chk("t2_latch"); chk_w("t2_latch_w");
        latch = 1'b0; dec = 1'b1; step = 4'd5;
        push(pk(8'd0, 1, 1, 1, 0, 0)); push_w(pk(8'd253, 0, 0, 1, 0, 0));
        cyc(); chk("t2_underflow"); chk_w("t2_underflow_w");
        dec = 1'b0;
        push(pk(8'd0, 1, 0, 0, 0, 0)); push_w(pk(8'd253, 0, 0, 0, 0, 0));
        cyc(); chk("t2_strobe_end"); chk_w("t2_strobe_end_w");

        // Overflow: saturate to 255 vs wrap to 4.
        latch = 1'b1; in_v = 8'd250;
        push(pk(8'd250, 0, 0, 0, 0, 0)); push_w(pk(8'd250, 0, 0, 0, 0, 0));
        cyc(); chk("t3_latch"); chk_w("t3_latch_w");
        latch = 1'b0; inc = 1'b1; step = 4'd10;
        push(pk(8'd255, 0, 0, 0, 1, 0)); push_w(pk(8'd4, 0, 0, 0, 1, 0));
        cyc(); chk("t3_overflow"); chk_w("t3_overflow_w");
        inc = 1'b0;
        push(pk(8'd255, 0, 0, 0, 0, 0)); push_w(pk(8'd4, 0, 0, 0, 0, 0));
        cyc(); chk("t3_strobe_end"); chk_w("t3_strobe_end_w");

        // Zero step: no change, no flags.
        dec = 1'b1; step = 4'd0;
        push(pk(8'd255, 0, 0, 0, 0, 0)); push_w(pk(8'd4, 0, 0, 0, 0, 0));
        cyc(); chk("step0_dec"); chk_w("step0_dec_w");

        // Latch beats a coincident dec.
        latch = 1'b1; in_v = 8'd3; step = 4'd1;
        push(pk(8'd3, 0, 0, 0, 0, 0)); cyc(); chk("t4_latch_prio");
        latch = 1'b0; dec = 1'b0;

        // Timer one-shot from 3: ticks every 4 edges, stops at 0.
        auto_reload = 1'b0; start = 1'b1;
        push(pk(8'd3, 0, 0, 0, 0, 1)); cyc(); chk("t4_start");
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            c = 3 - k / 4;
            push(pk(8'(c), c == 0, c == 0, 0, 0, k < 12));
            cyc(); chk("t4_run");
        end
        push(pk(8'd0, 1, 0, 0, 0, 0)); cyc(); chk("t4_after");

        // Timer auto-reload from 2: 1,0,2,... then stop freezes.
        latch = 1'b1; in_v = 8'd2; auto_reload = 1'b1;
        push(pk(8'd2, 0, 0, 0, 0, 0)); cyc(); chk("t5_latch");
        latch = 1'b0; start = 1'b1;
        push(pk(8'd2, 0, 0, 0, 0, 1)); cyc(); chk("t5_start");
        start = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            n  = k / 4;
            c  = 2 - (n % 3);
            zp = (c == 0) && (k % 4 == 0);
            push(pk(8'(c), c == 0, zp, 0, 0, 1));
            cyc(); chk("t5_run");
        end
        stop = 1'b1;
        push(pk(8'd2, 0, 0, 0, 0, 0)); cyc(); chk("t5_stop");
        stop = 1'b0;
        for (int k = 0; k < 6; k++) begin
            push(pk(8'd2, 0, 0, 0, 0, 0)); cyc(); chk("t5_hold");
        end

        // Asynchronous reset between edges while running.
        start = 1'b1;
        push(pk(8'd2, 0, 0, 0, 0, 1)); cyc(); chk("t6_start");
        start = 1'b0;
        push(pk(8'd2, 0, 0, 0, 0, 1)); cyc(); chk("t6_run");
        #3;
        reset = 1'b1;
        #1;
        push(pk(8'd0, 1, 0, 0, 0, 0)); chk("t6_async_reset");
        push_w(pk(8'd0, 1, 0, 0, 0, 0)); chk_w("t6_async_reset_w");
        cyc();
        reset = 1'b0;
        push(pk(8'd0, 1, 0, 0, 0, 0)); cyc(); chk("t6_release");

        // start and stop together from IDLE: stays IDLE.
        latch = 1'b1; in_v = 8'd5;
        push(pk(8'd5, 0, 0, 0, 0, 0)); cyc(); chk("t6_latch");
        latch = 1'b0; start = 1'b1; stop = 1'b1;
        push(pk(8'd5, 0, 0, 0, 0, 0)); cyc(); chk("t6_start_stop");
        start = 1'b0; stop = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push(pk(8'd5, 0, 0, 0, 0, 0)); cyc(); chk("t6_idle_hold");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
